// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial link bundle for piso_serializer
//
// Purpose: groups the parallel load handshake and the registered serial
//          link outputs of the serializer into one connection.
// Parameter: WIDTH - parallel word width in bits (2..32).
// Signals:
//   load_valid  upstream presents load_data
//   load_ready  serializer can accept a word this cycle
//   load_data   parallel word to transmit
//   ser_out     serial data bit
//   ser_valid   ser_out carries a valid bit
//   frame_start high with the MSB of each word
//   busy        serializer is shifting a word
// Modports: master = word source / link observer, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first
//
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and shifts
//          it out one bit per clock, MSB first, with zero-gap back-to-back
//          frames. Optional even parity bit after the LSB when the macro
//          PISO_PARITY_EN is defined (frame becomes WIDTH+1 bits).
// Parameter: WIDTH - data word width in bits, 2..32.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    piso_serializer_if.slave: load_valid/load_ready/load_data in,
//          ser_out/ser_valid/frame_start/busy out (all registered except
//          load_ready, which decodes the state registers)
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;   // bits still to send, left-aligned
  logic [CW-1:0]    cnt_q,   cnt_d;     // index of the bit currently on ser_out
  logic             ser_out_q, ser_out_d;
  logic             fs_q,    fs_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic load_ready_c;
  logic xfer;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      ser_out_q <= 1'b0;
      fs_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      ser_out_q <= ser_out_d;
      fs_q      <= fs_d;
`ifdef PISO_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ser_out_d = ser_out_q;
    fs_d      = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d  = parity_q;
`endif
    // load_data is only looked at on a real transfer, so X on an idle bus
    // never reaches the registers.
    if (xfer) begin
      state_d   = S_SHIFT;
      ser_out_d = bus.load_data[WIDTH-1];
      shreg_d   = {bus.load_data[WIDTH-2:0], 1'b0};
      cnt_d     = '0;
      fs_d      = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d  = ^bus.load_data;
`endif
    end else if (state_q == S_SHIFT) begin
      if (cnt_q == LAST) begin
        state_d   = S_IDLE;
        ser_out_d = 1'b0;
        shreg_d   = '0;
        cnt_d     = '0;
      end else begin
        cnt_d     = cnt_q + 1'b1;
        ser_out_d = shreg_q[WIDTH-1];
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
`ifdef PISO_PARITY_EN
        // LSB is on the line now; the parity bit follows it.
        if (cnt_q == CW'(WIDTH - 1)) begin
          ser_out_d = parity_q;
        end
`endif
      end
    end
  end

  // Output logic
  always_comb begin
    load_ready_c = (state_q == S_IDLE) || (cnt_q == LAST);
    xfer         = bus.load_valid && load_ready_c;
  end

  assign bus.load_ready  = load_ready_c;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = (state_q == S_SHIFT);
  assign bus.frame_start = fs_q;
  assign bus.busy        = (state_q == S_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int          FL      = WIDTH + 1;
  localparam logic [31:0] E_A5    = 32'h14A;
  localparam logic [31:0] E_FS1   = 32'h100;
  localparam logic [31:0] E_B2B   = 32'h29478;
  localparam logic [31:0] E_FSB2B = 32'h20100;
  localparam logic [31:0] E_FF    = 32'h1FE;
  localparam logic [31:0] E_81    = 32'h102;
`else
  localparam int          FL      = WIDTH;
  localparam logic [31:0] E_A5    = 32'hA5;
  localparam logic [31:0] E_FS1   = 32'h80;
  localparam logic [31:0] E_B2B   = 32'hA53C;
  localparam logic [31:0] E_FSB2B = 32'h8080;
  localparam logic [31:0] E_FF    = 32'hFF;
  localparam logic [31:0] E_81    = 32'h81;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(WIDTH)) bus_if ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Expected serial stream, one entry per future ser_valid cycle: {bit, frame_start}
  logic [1:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) mq.push_back({w[i], (i == WIDTH - 1)});
`ifdef PISO_PARITY_EN
    mq.push_back({^w, 1'b0});
`endif
  endfunction

  // Model: a word is accepted whenever at most one bit remains queued.
  initial begin : model
    logic xfer;
    forever begin
      @(posedge clk);
      xfer = (rst_n === 1'b1) && (bus_if.load_valid === 1'b1) && (mq.size() <= 1);
      if (rst_n !== 1'b1) begin
        mq.delete();
      end else begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (xfer) push_word(bus_if.load_data);
      end
    end
  end

  // Per-cycle compare against the model
  initial begin : compare
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = (mq.size() > 0) ? mq[0] : 2'b00;
        chk("cyc_ser_valid",   {31'd0, bus_if.ser_valid},   {31'd0, mq.size() > 0});
        chk("cyc_busy",        {31'd0, bus_if.busy},        {31'd0, mq.size() > 0});
        chk("cyc_ser_out",     {31'd0, bus_if.ser_out},     {31'd0, e[1]});
        chk("cyc_frame_start", {31'd0, bus_if.frame_start}, {31'd0, e[0]});
        chk("cyc_load_ready",  {31'd0, bus_if.load_ready},  {31'd0, mq.size() <= 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit keep);
    int n;
    n = 0;
    bus_if.load_valid = 1'b1;
    bus_if.load_data  = w;
    @(negedge clk);
    while (bus_if.load_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_timeout", n, (n < 100) ? n : 0);
    tick();
    if (!keep) begin
      bus_if.load_valid = 1'b0;
      bus_if.load_data  = 'x;
    end
  endtask

  task automatic capture(input int n, output logic [31:0] bits, output logic [31:0] fs,
                         output logic [31:0] rdy, output int vc);
    bits = '0; fs = '0; rdy = '0; vc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits = {bits[30:0], bus_if.ser_out};
      fs   = {fs[30:0], bus_if.frame_start};
      rdy  = {rdy[30:0], bus_if.load_ready};
      vc   = vc + int'(bus_if.ser_valid);
    end
  endtask

  initial begin : stim
    logic [31:0] b, f, r;
    int vc, cyc;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 'x;

    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, bus_if.load_ready}, 32'd1);
      chk("idle_valid", {31'd0, bus_if.ser_valid}, 32'd0);
      chk("idle_out",   {31'd0, bus_if.ser_out},   32'd0);
    end

    // Single word
    send_word(8'hA5, 1'b0);
    capture(FL, b, f, r, vc);
    chk("single_bits", b, E_A5);
    chk("single_fs", f, E_FS1);
    chk("single_ready", r, 32'd1);
    chk("single_vcnt", vc, FL);
    @(negedge clk);
    chk("single_drop", {31'd0, bus_if.ser_valid}, 32'd0);

    // Back-to-back
    repeat (2) tick();
    send_word(8'hA5, 1'b1);
    fork
      capture(2 * FL, b, f, r, vc);
      send_word(8'h3C, 1'b0);
    join
    chk("b2b_bits", b, E_B2B);
    chk("b2b_fs", f, E_FSB2B);
    chk("b2b_vcnt", vc, 2 * FL);
    repeat (FL + 2) tick();

    // Backpressure
    send_word(8'h5A, 1'b0);
    repeat (2) tick();
    bus_if.load_valid = 1'b1;
    bus_if.load_data  = 8'hFF;
    cyc = 3;
    @(negedge clk);
    while (bus_if.load_ready !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("bp_wait_cycles", cyc, FL);
    tick();
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 'x;
    capture(FL, b, f, r, vc);
    chk("bp_bits", b, E_FF);
    chk("bp_vcnt", vc, FL);
    repeat (3) tick();

    // Reset mid-word
    send_word(8'hF0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, bus_if.ser_valid}, 32'd0);
    chk("rst_mid_busy",  {31'd0, bus_if.busy},      32'd0);
    send_word(8'h81, 1'b0);
    capture(FL, b, f, r, vc);
    chk("after_rst_bits", b, E_81);
    repeat (3) tick();

`ifdef PISO_PARITY_EN
    send_word(8'h07, 1'b0);
    capture(FL, b, f, r, vc);
    chk("par07_bits", b, 32'h00F);
    chk("par07_ready", r, 32'd1);
    repeat (2) tick();
    send_word(8'h03, 1'b0);
    capture(FL, b, f, r, vc);
    chk("par03_bits", b, 32'h006);
    chk("par03_ready", r, 32'd1);
    repeat (2) tick();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first.
- It is the sending end of the single-bit registered serial link used by the basic-block capture flops and deserializers.
- It supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- load_valid  input  1  upstream presents load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  ser_out carries a valid bit this cycle, registered.
- frame_start  output  1  high with the first (MSB) bit of each word, registered.
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset: when rst_n=0 at posedge clk, the block enters IDLE with shift register=0, bit counter=0, ser_out=0, ser_valid=0, frame_start=0, busy=0. Reset overrides everything, including mid-word; the partial word is discarded and not resumed.
- Handshake: a transfer occurs on a posedge where load_valid && load_ready. load_data is sampled only at that edge. load_valid may be held high without a transfer while load_ready=0.
- load_ready is combinational from state: 1 in IDLE; 1 in SHIFT only during the last bit of the frame (counter==FRAME_LEN-1); 0 otherwise.
- FRAME_LEN = WIDTH, or WIDTH+1 with PARITY_EN.
- States:
  - IDLE: ser_valid=0, ser_out=0, busy=0. On transfer, load the shift register and clear the counter. The following cycle is SHIFT with ser_out=load_data[WIDTH-1], ser_valid=1, frame_start=1.
  - SHIFT: each cycle advances one bit, MSB to LSB, and the counter increments.
  - After the last bit: if a transfer occurs on that same edge, stay in SHIFT with the new word's MSB on the next cycle and frame_start=1 (zero-gap). Otherwise go to IDLE; ser_valid and busy drop to 0 the next cycle.
- Latency: the first bit appears 1 cycle after the accepting edge. Word n occupies exactly FRAME_LEN consecutive ser_valid cycles.
- frame_start is high for exactly one cycle per word, coincident with the MSB.
- The counter width is clog2(FRAME_LEN). The counter never wraps past FRAME_LEN-1.
- load_valid deasserting mid-frame has no effect on the frame in flight.
- X on load_data when no transfer occurs must not propagate.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: after the LSB, one extra ser_valid cycle carries even parity (XOR of all WIDTH data bits). FRAME_LEN=WIDTH+1. load_ready asserts during the parity cycle, not during the LSB.
- Undefined: no parity hardware; FRAME_LEN=WIDTH; the LSB cycle is last.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, load_valid=0 for 5 cycles -> ser_valid=0, ser_out=0, busy=0, load_ready=1 throughout.
- Single word: WIDTH=8, send 8'hA5 -> next 8 cycles ser_out=1,0,1,0,0,1,0,1; frame_start only on the first of them; ser_valid drops on cycle 9.
- Back-to-back: load_valid held high with 8'hA5 then 8'h3C -> 16 contiguous ser_valid cycles; frame_start on cycles 1 and 9; second frame bits 0,0,1,1,1,1,0,0.
- Backpressure: assert load_valid with 8'hFF on cycle 3 of a frame -> load_ready=0 until the last bit; word accepted on the last-bit edge; no bit lost or duplicated.
- Reset mid-word: rst_n=0 during bit 4 of 8'hF0 -> next cycle ser_valid=0, busy=0; after release, new word 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- PISO_PARITY_EN: send 8'h07 -> 9 ser_valid cycles, ninth bit=1; send 8'h03 -> ninth bit=0; load_ready high only on the ninth cycle of each.
